// File: rtl/multi_clk_gen_pkg.sv
// Shared types and constants for the multi-channel clock generator.
// Optional feature macro: MULTI_CLK_GEN_EDGE_EN. When it is defined, each
// channel also drives ch_rise/ch_fall edge pulses.
package multi_clk_gen_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 16;

  // Any requested period below this value is raised to it. Below two cycles,
  // a waveform cannot have both a high phase and a low phase.
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PHASE     = 2'd1,
    RUN       = 2'd2,
    STOP_PEND = 2'd3
  } ch_state_e;

  // Channel configuration at the default counter width. Channels built with a
  // non-default CNT_W declare the same layout locally at their own width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] phase;
  } ch_cfg_t;

endpackage

// File: rtl/multi_clk_gen_channel.sv
// One generator channel. It holds the FSM, the period/phase counter, the
// pending and active configuration, and the registered outputs.
// Optional feature macro: MULTI_CLK_GEN_EDGE_EN (adds ch_rise / ch_fall).
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | output low; waiting for ch_en
// PHASE     | start delay; cnt counts down from phase to 1, output low
// RUN       | cnt counts 0..period-1; output high while cnt < high
// STOP_PEND | ch_en dropped; finish the current period, then go to IDLE
module multi_clk_gen_channel
  import multi_clk_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_en,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             ch_out,
  output logic             ch_active,
`ifdef MULTI_CLK_GEN_EDGE_EN
  output logic             ch_rise,
  output logic             ch_fall,
`endif
  output logic             ch_wrap
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam cfg_t RST_CFG = '{period: MIN_P, high: ONE, phase: '0};

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             pend_q, pend_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic             out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             running_d;
  logic             at_wrap;
  cfg_t             load_cfg;
  cfg_t             next_cfg;

  // Clamp incoming config. When a load arrives on the same edge as a copy to
  // active, the copy uses the new values directly, bypassing the pending regs.
  always_comb begin
    load_cfg        = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
    if (cfg_period < MIN_P) begin
      load_cfg.period = MIN_P;
    end
    pend_d   = cfg_load ? load_cfg : pend_q;
    next_cfg = pend_d;
  end

  assign at_wrap = (cnt_q == act_period_q - ONE);

  // Channel FSM and counter next-state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_period_d = act_period_q;
    act_high_d   = act_high_q;
    case (state_q)
      IDLE: begin
        if (ch_en) begin
          act_period_d = next_cfg.period;
          act_high_d   = next_cfg.high;
          if (next_cfg.phase == '0) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d = PHASE;
            cnt_d   = next_cfg.phase;
          end
        end
      end
      PHASE: begin
        if (!ch_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RUN, STOP_PEND: begin
        if (at_wrap) begin
          cnt_d = '0;
          if (ch_en) begin
            state_d      = RUN;
            act_period_d = next_cfg.period;
            act_high_d   = next_cfg.high;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (ch_en) begin
            state_d = RUN;
          end else begin
            state_d = STOP_PEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next counter value, so they line up with
  // the cycle the counter is in. They stay low outside RUN and STOP_PEND.
  always_comb begin
    running_d = (state_d == RUN) || (state_d == STOP_PEND);
    out_d     = running_d && (cnt_d < act_high_d);
    wrap_d    = running_d && (cnt_d == act_period_d - ONE);
  end

  // State, counter, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= RST_CFG;
      act_period_q <= RST_CFG.period;
      act_high_q   <= RST_CFG.high;
      out_q        <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      act_period_q <= act_period_d;
      act_high_q   <= act_high_d;
      out_q        <= out_d;
      wrap_q       <= wrap_d;
    end
  end

  assign ch_out    = out_q;
  assign ch_wrap   = wrap_q;
  assign ch_active = (state_q != IDLE);

`ifdef MULTI_CLK_GEN_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Edge pulses are registered on the same edge that ch_out changes.
  always_comb begin
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // Edge pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign ch_rise = rise_q;
  assign ch_fall = fall_q;
`endif

endmodule

// File: rtl/multi_clk_gen.sv
// Multi-channel programmable clock/waveform generator. NUM_CH channels run
// independently from one reference clock.
// Optional feature macro: MULTI_CLK_GEN_EDGE_EN (adds ch_rise / ch_fall).
module multi_clk_gen
  import multi_clk_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_high,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       ch_out,
  output logic [NUM_CH-1:0]       ch_active,
`ifdef MULTI_CLK_GEN_EDGE_EN
  output logic [NUM_CH-1:0]       ch_rise,
  output logic [NUM_CH-1:0]       ch_fall,
`endif
  output logic [NUM_CH-1:0]       ch_wrap
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_clk_gen_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .ch_en     (ch_en[i]),
      .cfg_load  (cfg_load[i]),
      .cfg_period(cfg_period[i*CNT_W +: CNT_W]),
      .cfg_high  (cfg_high[i*CNT_W +: CNT_W]),
      .cfg_phase (cfg_phase[i*CNT_W +: CNT_W]),
      .ch_out    (ch_out[i]),
      .ch_active (ch_active[i]),
`ifdef MULTI_CLK_GEN_EDGE_EN
      .ch_rise   (ch_rise[i]),
      .ch_fall   (ch_fall[i]),
`endif
      .ch_wrap   (ch_wrap[i])
    );
  end

endmodule
